tx_queue_scheduler: RTL and testbench

TX_QUEUE_SCHEDULER -- requirements
Module: tx_queue_scheduler

---
 rtl/tx_queue_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_tx_queue_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_queue_scheduler
// Purpose  : Round-robin scheduler that hands the single tx MAC engine to one
//            of four tx queues, with per-queue burst limiting, a busy-timeout
//            abort and optional per-queue completed-frame counters.
// Ports    : clk         - sole clock, all logic on posedge
//            reset_n     - asynchronous active-low reset
//            req[3:0]    - level request per queue (queue holds a full frame)
//            grant[3:0]  - one-hot engine owner, zero when idle
//            eng_start   - one-cycle launch pulse for queue eng_sel
//            eng_sel     - granted queue index, held until release
//            eng_done    - end-of-frame pulse from the engine (BUSY only)
//            eng_abort   - one-cycle abort pulse on timeout
//            timeout_err - sticky timeout flag, cleared by err_clr
//            err_clr     - synchronous clear of timeout_err (set wins)
//            frames_sent - 4x32 completed-frame counters, queue i at
//                          [32i+31:32i] (only with TX_SCHED_STATS_EN)
// Config   : define TX_SCHED_STATS_EN to build the frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module tx_queue_scheduler #(
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req,
  output logic [3:0]   grant,
  output logic         eng_start,
  output logic [1:0]   eng_sel,
  input  logic         eng_done,
  output logic         eng_abort,
  output logic         timeout_err,
  input  logic         err_clr
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [127:0] frames_sent
`endif
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam int            BW         = $clog2(BURST_MAX + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic          eng_start_q, eng_start_d;
  logic [1:0]    eng_sel_q, eng_sel_d;
  logic          eng_abort_q, eng_abort_d;
  logic          timeout_err_q, timeout_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]    last_q_q, last_q_d;

  logic          keep_last;
  logic [1:0]    rr_pick;
  logic [1:0]    pick;
  logic          err_set;

  // Arbitration. burst_cnt of zero only occurs straight after reset and means
  // "no history", so the search then starts at last_q+1 = queue 0. The
  // descending loop lets the nearest requester after last_q win; offset 4
  // wraps back to last_q itself, covering the sole-requester re-grant.
  always_comb begin
    keep_last = req[last_q_q] && (burst_cnt_q != '0) && (burst_cnt_q < BURST_LIM);
    rr_pick   = last_q_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[last_q_q + 2'(k)]) begin
        rr_pick = last_q_q + 2'(k);
      end
    end
    pick = keep_last ? last_q_q : rr_pick;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    eng_start_d = 1'b0;
    eng_sel_d   = eng_sel_q;
    eng_abort_d = 1'b0;
    timer_d     = timer_q;
    burst_cnt_d = burst_cnt_q;
    last_q_d    = last_q_q;
    err_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        timer_d = '0;
        if (|req) begin
          state_d     = ST_START;
          eng_start_d = 1'b1;
          eng_sel_d   = pick;
          grant_d     = 4'b0001 << pick;
          // Re-granting last_q without the burst keep means a fresh burst;
          // zero here so the completion increment lands on 1.
          if (!keep_last && (pick == last_q_q)) begin
            burst_cnt_d = '0;
          end
        end
      end

      ST_START: begin
        timer_d = timer_q + TW'(1);
        state_d = ST_BUSY;
      end

      ST_BUSY: begin
        if (eng_done) begin
          // Completion has priority over a timeout in the same cycle.
          state_d     = ST_IDLE;
          grant_d     = '0;
          last_q_d    = eng_sel_q;
          burst_cnt_d = (eng_sel_q == last_q_q) ? burst_cnt_q + BW'(1) : BW'(1);
        end else if (timer_q == TIMER_LAST) begin
          // Saturated burst count forces rotation away from the stuck queue.
          state_d     = ST_IDLE;
          grant_d     = '0;
          eng_abort_d = 1'b1;
          err_set     = 1'b1;
          last_q_d    = eng_sel_q;
          burst_cnt_d = BURST_LIM;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    timeout_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      eng_start_q   <= 1'b0;
      eng_sel_q     <= '0;
      eng_abort_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
      burst_cnt_q   <= '0;
      last_q_q      <= 2'd3;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      eng_start_q   <= eng_start_d;
      eng_sel_q     <= eng_sel_d;
      eng_abort_q   <= eng_abort_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
      burst_cnt_q   <= burst_cnt_d;
      last_q_q      <= last_q_d;
    end
  end

  assign grant       = grant_q;
  assign eng_start   = eng_start_q;
  assign eng_sel     = eng_sel_q;
  assign eng_abort   = eng_abort_q;
  assign timeout_err = timeout_err_q;

`ifdef TX_SCHED_STATS_EN
  logic [31:0] cnt_q [4];
  logic [31:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_BUSY) && eng_done) begin
      cnt_d[eng_sel_q] = cnt_q[eng_sel_q] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign frames_sent = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_queue_scheduler
// Purpose  : Self-checking bench for tx_queue_scheduler. A queue/owner level
//            model predicts every output each cycle; directed scenarios pin
//            hand-computed values (latency, burst order, timeout distance,
//            done/timeout and clear/set priority, reset mid-frame, counters).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_queue_scheduler;

  localparam int BURST_MAX = 4;
  localparam int TIMEOUT   = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic         eng_done = 1'b0;
  logic         err_clr = 1'b0;
  logic [3:0]   grant;
  logic         eng_start;
  logic [1:0]   eng_sel;
  logic         eng_abort;
  logic         timeout_err;
`ifdef TX_SCHED_STATS_EN
  logic [127:0] frames_sent;
`endif

  tx_queue_scheduler #(
    .BURST_MAX (BURST_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .eng_start   (eng_start),
    .eng_sel     (eng_sel),
    .eng_done    (eng_done),
    .eng_abort   (eng_abort),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
`ifdef TX_SCHED_STATS_EN
    ,
    .frames_sent (frames_sent)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = queue holding the engine (-1 none); age = cycles since its start.
  int          m_owner = -1;
  int          m_age   = 0;
  int          m_last  = 3;
  int          m_burst = 0;
  int          m_sel   = 0;
  bit          m_abort = 1'b0;
  bit          m_err   = 1'b0;
  logic [31:0] m_cnt [4];
  bit          m_to;

  function automatic int pick(input logic [3:0] r, input int last, input int burst);
    if (burst > 0 && burst < BURST_MAX && r[last] == 1'b1) return last;
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4] == 1'b1) return (last + k) % 4;
    end
    return -1;
  endfunction

  assign m_to = (m_owner >= 0) && (m_age != 0) && !eng_done && (m_age == TIMEOUT - 1);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1;
      m_age   <= 0;
      m_last  <= 3;
      m_burst <= 0;
      m_sel   <= 0;
      m_abort <= 1'b0;
      m_err   <= 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= '0;
    end else begin
      m_abort <= 1'b0;
      if (m_owner < 0) begin
        if (req != 4'b0000) begin
          m_owner <= pick(req, m_last, m_burst);
          m_sel   <= pick(req, m_last, m_burst);
          m_age   <= 0;
        end
      end else if (m_age == 0) begin
        m_age <= 1;
      end else if (eng_done) begin
        m_cnt[m_owner] <= m_cnt[m_owner] + 32'd1;
        m_burst <= (m_owner == m_last && m_burst < BURST_MAX) ? m_burst + 1 : 1;
        m_last  <= m_owner;
        m_owner <= -1;
      end else if (m_to) begin
        m_abort <= 1'b1;
        m_last  <= m_owner;
        m_burst <= BURST_MAX;
        m_owner <= -1;
      end else begin
        m_age <= m_age + 1;
      end
      if (m_to) m_err <= 1'b1;
      else if (err_clr) m_err <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("grant", 128'(grant), 128'((m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000));
    chk("eng_start", 128'(eng_start), 128'(m_owner >= 0 && m_age == 0));
    chk("eng_sel", 128'(eng_sel), 128'(m_sel[1:0]));
    chk("eng_abort", 128'(eng_abort), 128'(m_abort));
    chk("timeout_err", 128'(timeout_err), 128'(m_err));
`ifdef TX_SCHED_STATS_EN
    chk("frames_sent", frames_sent, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req      = 4'b0000;
    eng_done = 1'b0;
    err_clr  = 1'b0;
    tick(2);
    reset_n  = 1'b1;
  endtask

  task automatic wait_start(output int s_cyc, output int s_sel);
    int n;
    n = 0;
    while (!eng_start && n < 60) begin
      tick(1);
      n++;
    end
    chk("start_seen", 128'(eng_start), 128'(1));
    s_cyc = cyc;
    s_sel = int'(eng_sel);
  endtask

  task automatic frame(input int d, output int s_cyc, output int s_sel);
    wait_start(s_cyc, s_sel);
    tick(d);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
  endtask

  int sc, ss, prev, n;
  int seq [9];
  int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_sel", 128'(eng_sel), 128'(0));
    chk("rst_err", 128'(timeout_err), 128'(0));
    tick(2);
    reset_n = 1'b1;

    // Single frame latency and release
    req = 4'b0001;
    tick(1);
    chk("lat_start", 128'(eng_start), 128'(1));
    chk("lat_sel", 128'(eng_sel), 128'(0));
    chk("lat_grant", 128'(grant), 128'(4'b0001));
    req = 4'b0000;
    tick(4);
    chk("busy_grant_c5", 128'(grant), 128'(4'b0001));
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    chk("release_grant", 128'(grant), 128'(0));

    // All queues requesting: burst of 4 then rotate
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) frame(4, sc, seq[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("burst_seq[%0d]", i), 128'(seq[i]), 128'(exp_seq[i]));
    req = 4'b0000;
    tick(2);

    // Sole requester keeps the engine past the burst limit, spacing >= 3
    do_reset();
    req = 4'b0100;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      frame(1, sc, ss);
      chk("solo_sel", 128'(ss), 128'(2));
      if (i > 0) chk("start_spacing", 128'(sc - prev >= 3), 128'(1));
      prev = sc;
    end

    // Reset mid-frame: grant drops at once, no abort; search restarts at 0
    req = 4'b1111;
    wait_start(sc, ss);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("midrst_grant", 128'(grant), 128'(0));
    chk("midrst_abort", 128'(eng_abort), 128'(0));
    tick(2);
    reset_n = 1'b1;
    wait_start(sc, ss);
    chk("midrst_first_sel", 128'(ss), 128'(0));
    tick(1);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    req = 4'b0000;
    tick(2);

    // Timeout on queue 1, then rotation to queue 2
    do_reset();
    req = 4'b0010;
    wait_start(sc, ss);
    chk("to_sel", 128'(ss), 128'(1));
    req = 4'b0110;
    n = 0;
    while (!eng_abort && n < 40) begin
      tick(1);
      n++;
    end
    chk("abort_distance", 128'(n), 128'(16));
    chk("abort_err", 128'(timeout_err), 128'(1));
    wait_start(sc, ss);
    chk("after_abort_sel", 128'(ss), 128'(2));
    tick(1);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", 128'(timeout_err), 128'(0));

    // Done in the timeout cycle wins
    wait_start(sc, ss);
    tick(15);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    chk("done_wins_abort", 128'(eng_abort), 128'(0));
    chk("done_wins_err", 128'(timeout_err), 128'(0));

    // Timeout set wins over concurrent clear
    wait_start(sc, ss);
    tick(15);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("set_wins_abort", 128'(eng_abort), 128'(1));
    chk("set_wins_err", 128'(timeout_err), 128'(1));
    req = 4'b0000;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared2", 128'(timeout_err), 128'(0));

`ifdef TX_SCHED_STATS_EN
    // Counters: 3 frames on queue 3, one aborted frame on queue 0
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 3; i++) frame(2, sc, ss);
    req = 4'b0001;
    wait_start(sc, ss);
    chk("stats_abort_sel", 128'(ss), 128'(0));
    n = 0;
    while (!eng_abort && n < 40) begin
      tick(1);
      n++;
    end
    req = 4'b0000;
    tick(1);
    chk("stats_q3", 128'(frames_sent[127:96]), 128'(3));
    chk("stats_q0", 128'(frames_sent[31:0]), 128'(0));
    req = 4'b0010;
    wait_start(sc, ss);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("stats_rst", frames_sent, 128'(0));
    tick(2);
    reset_n = 1'b1;
    req = 4'b0000;
`endif

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
